// File: rtl/artemis_mcb_burst_ctrl.sv
// Drives Artemis DDR3 MCB user port 3 for one host burst: write FIFO fill followed by a WRITE
// command, or a READ command followed by a read FIFO drain with a no-data timeout.
module artemis_mcb_burst_ctrl #(
    parameter bit          USE_PRECHARGE = 1'b0,
    parameter int unsigned RD_TIMEOUT    = 1024
) (
    input  logic        p3_cmd_clk,
    input  logic        rst,
    input  logic        calibration_done,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [27:0] req_addr,
    input  logic [6:0]  req_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        p3_cmd_en,
    output logic [2:0]  p3_cmd_instr,
    output logic [5:0]  p3_cmd_bl,
    output logic [29:0] p3_cmd_byte_addr,
    input  logic        p3_cmd_full,
    output logic        p3_wr_en,
    output logic [3:0]  p3_wr_mask,
    output logic [31:0] p3_wr_data,
    input  logic        p3_wr_full,
    output logic        p3_rd_en,
    input  logic [31:0] p3_rd_data,
    input  logic        p3_rd_empty
);

    localparam int unsigned    TmoW    = $clog2(RD_TIMEOUT);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(RD_TIMEOUT - 1);
    localparam logic [2:0]     InstrWr = USE_PRECHARGE ? 3'b010 : 3'b000;
    localparam logic [2:0]     InstrRd = USE_PRECHARGE ? 3'b011 : 3'b001;

    typedef enum logic [2:0] {
        StIdle, StWrFill, StWrCmd, StRdCmd, StRdDrain, StFin
    } state_e;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [27:0]     addr_q, addr_d;
    logic [6:0]      len_q, len_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            cmd_issue;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        cmd_issue   = 1'b0;
        req_ready   = (state_q == StIdle) && calibration_done;
        wdata_ready = 1'b0;
        p3_wr_en    = 1'b0;
        p3_wr_data  = 32'h0;
        p3_wr_mask  = 4'h0;
        p3_rd_en    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = 7'd0;
                    tmo_d   = '0;
                    if (req_len == 7'd0 || req_len > 7'd64) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        err_d   = 1'b0;
                        state_d = req_write ? StWrFill : StRdCmd;
                    end
                end
            end
            StWrFill: begin
                wdata_ready = !p3_wr_full;
                p3_wr_en    = wdata_valid && !p3_wr_full;
                p3_wr_data  = wdata;
                p3_wr_mask  = ~wbe;
                if (p3_wr_en) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == len_q - 7'd1) state_d = StWrCmd;
                end
            end
            StWrCmd, StRdCmd: begin
                if (!p3_cmd_full) begin
                    cmd_issue = 1'b1;
                    cnt_d     = 7'd0;
                    tmo_d     = '0;
                    state_d   = (state_q == StWrCmd) ? StFin : StRdDrain;
                end
            end
            StRdDrain: begin
                p3_rd_en = !p3_rd_empty;
                if (p3_rd_en) begin
                    cnt_d = cnt_q + 7'd1;
                    tmo_d = '0;
                    if (cnt_q == len_q - 7'd1) state_d = StFin;
                end else if (tmo_q == TmoLast) begin
                    // Leftover FIFO words are not flushed here.
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StFin: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge p3_cmd_clk) begin
        if (rst) begin
            state_q          <= StIdle;
            write_q          <= 1'b0;
            addr_q           <= 28'h0;
            len_q            <= 7'd0;
            cnt_q            <= 7'd0;
            tmo_q            <= '0;
            err_q            <= 1'b0;
            p3_cmd_en        <= 1'b0;
            p3_cmd_instr     <= 3'b000;
            p3_cmd_bl        <= 6'h0;
            p3_cmd_byte_addr <= 30'h0;
            rdata_valid      <= 1'b0;
            rdata            <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            p3_cmd_en   <= cmd_issue;
            rdata_valid <= p3_rd_en;
            if (cmd_issue) begin
                p3_cmd_instr     <= write_q ? InstrWr : InstrRd;
                p3_cmd_bl        <= 6'(len_q - 7'd1);
                p3_cmd_byte_addr <= {addr_q, 2'b00};
            end
            if (p3_rd_en) rdata <= p3_rd_data;
        end
    end

endmodule

// File: tb/tb_artemis_mcb_burst_ctrl.sv
// Self-checking bench for artemis_mcb_burst_ctrl: host and MCB FIFO models plus a transaction-level
// reference (expected beats, command word, read stream and done/err timing per request).
module tb_artemis_mcb_burst_ctrl;

    localparam int unsigned RdTimeout = 16;

    logic        p3_cmd_clk = 1'b0;
    logic        rst = 1'b1, calibration_done = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [27:0] req_addr = '0;
    logic [6:0]  req_len = '0;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        p3_cmd_full = 1'b0, p3_wr_full = 1'b0, p3_rd_empty = 1'b1;
    logic [31:0] p3_rd_data = '0;

    logic        req_ready, wdata_ready, rdata_valid, done, err, p3_cmd_en, p3_wr_en, p3_rd_en;
    logic [31:0] rdata, p3_wr_data;
    logic [2:0]  p3_cmd_instr;
    logic [5:0]  p3_cmd_bl;
    logic [29:0] p3_cmd_byte_addr;
    logic [3:0]  p3_wr_mask;

    logic        d0_req_ready, d0_wdata_ready, d0_rdata_valid, d0_done, d0_err, d0_cmd_en;
    logic        d0_wr_en, d0_rd_en;
    logic [31:0] d0_rdata, d0_wr_data;
    logic [2:0]  d0_cmd_instr;
    logic [5:0]  d0_cmd_bl;
    logic [29:0] d0_cmd_byte_addr;
    logic [3:0]  d0_wr_mask;

    always #5 p3_cmd_clk = ~p3_cmd_clk;

    artemis_mcb_burst_ctrl #(.USE_PRECHARGE(1'b1), .RD_TIMEOUT(RdTimeout)) u_dut (
        .p3_cmd_clk(p3_cmd_clk), .rst(rst), .calibration_done(calibration_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready), .wdata(wdata), .wbe(wbe), .rdata_valid(rdata_valid),
        .rdata(rdata), .done(done), .err(err), .p3_cmd_en(p3_cmd_en),
        .p3_cmd_instr(p3_cmd_instr), .p3_cmd_bl(p3_cmd_bl),
        .p3_cmd_byte_addr(p3_cmd_byte_addr), .p3_cmd_full(p3_cmd_full), .p3_wr_en(p3_wr_en),
        .p3_wr_mask(p3_wr_mask), .p3_wr_data(p3_wr_data), .p3_wr_full(p3_wr_full),
        .p3_rd_en(p3_rd_en), .p3_rd_data(p3_rd_data), .p3_rd_empty(p3_rd_empty)
    );

    // Plain-command variant sharing all inputs; only its command opcode is inspected.
    artemis_mcb_burst_ctrl #(.USE_PRECHARGE(1'b0), .RD_TIMEOUT(RdTimeout)) u_dut0 (
        .p3_cmd_clk(p3_cmd_clk), .rst(rst), .calibration_done(calibration_done),
        .req_valid(req_valid), .req_ready(d0_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .wdata_valid(wdata_valid),
        .wdata_ready(d0_wdata_ready), .wdata(wdata), .wbe(wbe), .rdata_valid(d0_rdata_valid),
        .rdata(d0_rdata), .done(d0_done), .err(d0_err), .p3_cmd_en(d0_cmd_en),
        .p3_cmd_instr(d0_cmd_instr), .p3_cmd_bl(d0_cmd_bl),
        .p3_cmd_byte_addr(d0_cmd_byte_addr), .p3_cmd_full(p3_cmd_full), .p3_wr_en(d0_wr_en),
        .p3_wr_mask(d0_wr_mask), .p3_wr_data(d0_wr_data), .p3_wr_full(p3_wr_full),
        .p3_rd_en(d0_rd_en), .p3_rd_data(p3_rd_data), .p3_rd_empty(p3_rd_empty)
    );

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge p3_cmd_clk) cyc <= cyc + 1;

    bit wr_full_force = 0, cmd_full_force = 0, rnd_full = 0, rnd_wgap = 0, rnd_empty = 0;
    logic [35:0] hostq[$];
    logic [31:0] rfifo[$];
    logic [35:0] exp_wr[$];
    logic [31:0] rd_src[$];

    logic [35:0] wr_obs[$];
    logic [38:0] cmd_obs[$];
    logic [2:0]  d0_instr_obs[$];
    logic [31:0] rd_obs[$];
    int n_done = 0, done_cyc = 0, cmd_cyc = 0, last_cmdfull_cyc = 0, last_pop_cyc = 0;
    int last_rdv_cyc = 0, last_wr_cyc = 0;
    bit done_err = 0;
    int hs_bad = 0, rdy_bad = 0, rd_bad = 0, errnd_bad = 0;

    // Host write source and MCB FIFO side, applied 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge p3_cmd_clk);
            #2;
            wdata_valid = (hostq.size() > 0) && (!rnd_wgap || $urandom_range(3) != 0);
            if (hostq.size() > 0) {wbe, wdata} = hostq[0];
            p3_wr_full  = wr_full_force || (rnd_full && $urandom_range(3) == 0);
            p3_cmd_full = cmd_full_force || (rnd_full && $urandom_range(3) == 0);
            p3_rd_empty = (rfifo.size() == 0) ||
                          (rnd_empty && (cyc % 4 != 0) && $urandom_range(1) == 1);
            p3_rd_data  = (rfifo.size() > 0) ? rfifo[0] : $urandom;
        end
    end

    initial begin
        forever begin
            @(negedge p3_cmd_clk);
            if (wdata_valid && wdata_ready && hostq.size() > 0) void'(hostq.pop_front());
            if (p3_wr_en) begin
                wr_obs.push_back({p3_wr_mask, p3_wr_data});
                last_wr_cyc = cyc;
            end
            if (p3_wr_en != (wdata_valid && wdata_ready)) hs_bad++;
            if (wdata_ready && p3_wr_full) rdy_bad++;
            if (p3_cmd_full) last_cmdfull_cyc = cyc;
            if (p3_cmd_en) begin
                cmd_obs.push_back({p3_cmd_instr, p3_cmd_bl, p3_cmd_byte_addr});
                cmd_cyc = cyc;
            end
            if (d0_cmd_en) d0_instr_obs.push_back(d0_cmd_instr);
            if (p3_rd_en && !p3_rd_empty) begin
                void'(rfifo.pop_front());
                last_pop_cyc = cyc;
            end
            if (p3_rd_en && p3_rd_empty) rd_bad++;
            if (rdata_valid) begin
                rd_obs.push_back(rdata);
                last_rdv_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                done_err = err;
            end
            if (err && !done) errnd_bad++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    task automatic clr_obs();
        wr_obs.delete();
        cmd_obs.delete();
        d0_instr_obs.delete();
        rd_obs.delete();
        n_done = 0;
    endtask

    task automatic do_req(input bit w, input logic [27:0] a, input logic [6:0] l,
                          output int acc, output bit tout);
        int k;
        acc = -1;
        tout = 1'b0;
        k = 0;
        @(posedge p3_cmd_clk);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        forever begin
            @(negedge p3_cmd_clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
            k++;
            if (k > 100) begin
                tout = 1'b1;
                break;
            end
        end
        @(posedge p3_cmd_clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        while (!tout && n_done == 0) begin
            @(posedge p3_cmd_clk);
            #3;
            k++;
            if (k > 3000) tout = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge p3_cmd_clk);
        @(negedge p3_cmd_clk);
        n_cmp++;
        if ({done, err, req_ready, wdata_ready, rdata_valid, p3_cmd_en, p3_wr_en, p3_rd_en}
            !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {done, err, req_ready, wdata_ready, rdata_valid, p3_cmd_en, p3_wr_en, p3_rd_en});
        end
        n_cmp++;
        if ({p3_cmd_instr, p3_cmd_bl, p3_cmd_byte_addr, rdata, p3_wr_mask, p3_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: instr=%h bl=%h addr=%h rdata=%h mask=%h wdata=%h want 0",
                     p3_cmd_instr, p3_cmd_bl, p3_cmd_byte_addr, rdata, p3_wr_mask, p3_wr_data);
        end
        @(posedge p3_cmd_clk);
        #1 rst = 1'b0;
        @(negedge p3_cmd_clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_uncal: got %b want 0", req_ready);
        end
        @(posedge p3_cmd_clk);
        #1 calibration_done = 1'b1;
        @(negedge p3_cmd_clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_cal: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_basic();
        int acc;
        bit tout;
        clr_obs();
        for (int i = 1; i <= 4; i++) hostq.push_back({4'hF, 32'(i)});
        do_req(1'b1, 28'h10, 7'd4, acc, tout);
        n_cmp++;
        if (tout || wr_obs.size() != 4) begin
            n_fail++;
            $display("FAIL wr4_beats: got %0d beats (timeout=%0b) want 4", wr_obs.size(), tout);
        end
        for (int i = 0; i < 4 && i < wr_obs.size(); i++) begin
            n_cmp++;
            if (wr_obs[i] !== {4'h0, 32'(i + 1)}) begin
                n_fail++;
                $display("FAIL wr4_word%0d: got %h want %h", i, wr_obs[i], {4'h0, 32'(i + 1)});
            end
        end
        n_cmp++;
        if (cmd_obs.size() != 1 || cmd_obs[0] !== {3'b010, 6'd3, 30'h40}) begin
            n_fail++;
            $display("FAIL wr4_cmd: got n=%0d %h want 1 x %h", cmd_obs.size(),
                     (cmd_obs.size() > 0) ? cmd_obs[0] : 39'h0, {3'b010, 6'd3, 30'h40});
        end
        n_cmp++;
        if (d0_instr_obs.size() != 1 || d0_instr_obs[0] !== 3'b000) begin
            n_fail++;
            $display("FAIL wr4_plain_instr: got n=%0d want one 000", d0_instr_obs.size());
        end
        n_cmp++;
        if (cmd_cyc != last_wr_cyc + 2 || done_cyc != cmd_cyc || n_done != 1 || done_err) begin
            n_fail++;
            $display("FAIL wr4_timing: beat@%0d cmd@%0d done@%0d n=%0d err=%0b want cmd=beat+2=done",
                     last_wr_cyc, cmd_cyc, done_cyc, n_done, done_err);
        end
    endtask

    task automatic test_write_stall();
        int acc;
        bit tout;
        logic [35:0] w;
        clr_obs();
        exp_wr.delete();
        for (int i = 0; i < 8; i++) begin
            w = {4'($urandom), $urandom};
            hostq.push_back(w);
            exp_wr.push_back({~w[35:32], w[31:0]});
        end
        cmd_full_force = 1'b1;
        fork
            do_req(1'b1, 28'h0ABCDE, 7'd8, acc, tout);
            begin
                int k = 0;
                while (wr_obs.size() < 3 && k < 200) begin
                    @(posedge p3_cmd_clk);
                    #1 k++;
                end
                wr_full_force = 1'b1;
                repeat (3) @(posedge p3_cmd_clk);
                #1 wr_full_force = 1'b0;
                while (wr_obs.size() < 8 && k < 400) begin
                    @(posedge p3_cmd_clk);
                    #1 k++;
                end
                repeat (2) @(posedge p3_cmd_clk);
                #1 cmd_full_force = 1'b0;
            end
        join
        n_cmp++;
        if (tout || wr_obs.size() != 8) begin
            n_fail++;
            $display("FAIL stall_beats: got %0d (timeout=%0b) want 8", wr_obs.size(), tout);
        end
        for (int i = 0; i < 8 && i < wr_obs.size(); i++) begin
            n_cmp++;
            if (wr_obs[i] !== exp_wr[i]) begin
                n_fail++;
                $display("FAIL stall_word%0d: got %h want %h", i, wr_obs[i], exp_wr[i]);
            end
        end
        n_cmp++;
        if (cmd_obs.size() != 1 || cmd_cyc != last_cmdfull_cyc + 2 || done_cyc != cmd_cyc) begin
            n_fail++;
            $display("FAIL stall_cmd: n=%0d cmd@%0d lastfull@%0d done@%0d want 1, cmd=full+2=done",
                     cmd_obs.size(), cmd_cyc, last_cmdfull_cyc, done_cyc);
        end
        n_cmp++;
        if (rdy_bad != 0 || hs_bad != 0) begin
            n_fail++;
            $display("FAIL stall_ready: ready-while-full=%0d handshake-mismatch=%0d want 0 0",
                     rdy_bad, hs_bad);
        end
    endtask

    task automatic test_read_64();
        int acc;
        bit tout;
        clr_obs();
        rd_src.delete();
        rnd_empty = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd_src.push_back($urandom);
            rfifo.push_back(rd_src[i]);
        end
        do_req(1'b0, 28'h100, 7'd64, acc, tout);
        n_cmp++;
        if (tout || cmd_obs.size() != 1 || cmd_obs[0] !== {3'b011, 6'h3F, 30'h400}) begin
            n_fail++;
            $display("FAIL rd64_cmd: n=%0d got %h want %h (timeout=%0b)", cmd_obs.size(),
                     (cmd_obs.size() > 0) ? cmd_obs[0] : 39'h0, {3'b011, 6'h3F, 30'h400}, tout);
        end
        n_cmp++;
        if (d0_instr_obs.size() != 1 || d0_instr_obs[0] !== 3'b001) begin
            n_fail++;
            $display("FAIL rd64_plain_instr: got n=%0d want one 001", d0_instr_obs.size());
        end
        n_cmp++;
        if (rd_obs.size() != 64) begin
            n_fail++;
            $display("FAIL rd64_count: got %0d want 64", rd_obs.size());
        end
        for (int i = 0; i < 64 && i < rd_obs.size(); i++) begin
            n_cmp++;
            if (rd_obs[i] !== rd_src[i]) begin
                n_fail++;
                $display("FAIL rd64_word%0d: got %h want %h", i, rd_obs[i], rd_src[i]);
            end
        end
        n_cmp++;
        if (done_cyc != last_rdv_cyc || done_err || n_done != 1 || rd_bad != 0) begin
            n_fail++;
            $display("FAIL rd64_done: done@%0d lastvalid@%0d err=%0b n=%0d rdbad=%0d",
                     done_cyc, last_rdv_cyc, done_err, n_done, rd_bad);
        end
        rnd_empty = 1'b0;
    endtask

    task automatic test_read_timeout();
        int acc;
        bit tout;
        logic [31:0] wd;
        clr_obs();
        wd = $urandom;
        rfifo.push_back(wd);
        do_req(1'b0, 28'($urandom), 7'd2, acc, tout);
        n_cmp++;
        if (tout || rd_obs.size() != 1 || rd_obs[0] !== wd) begin
            n_fail++;
            $display("FAIL tmo_data: n=%0d got %h want 1 x %h (timeout=%0b)", rd_obs.size(),
                     (rd_obs.size() > 0) ? rd_obs[0] : 32'h0, wd, tout);
        end
        n_cmp++;
        if (!done_err || done_cyc != last_pop_cyc + int'(RdTimeout) + 1) begin
            n_fail++;
            $display("FAIL tmo_done: err=%0b done@%0d want err=1 done@%0d", done_err, done_cyc,
                     last_pop_cyc + int'(RdTimeout) + 1);
        end
    endtask

    task automatic test_illegal_len();
        int acc;
        bit tout;
        logic [6:0] lens[3];
        lens[0] = 7'd0;
        lens[1] = 7'd65;
        lens[2] = 7'($urandom_range(127, 66));
        for (int i = 0; i < 3; i++) begin
            clr_obs();
            for (int j = 0; j < 4; j++) hostq.push_back({4'hF, $urandom});
            do_req(i != 1, 28'($urandom), lens[i], acc, tout);
            repeat (3) @(posedge p3_cmd_clk);
            n_cmp++;
            if (tout || done_cyc != acc + 1 || !done_err || n_done != 1 ||
                wr_obs.size() != 0 || cmd_obs.size() != 0) begin
                n_fail++;
                $display("FAIL illegal_len%0d: acc@%0d done@%0d err=%0b n=%0d wr=%0d cmd=%0d",
                         lens[i], acc, done_cyc, done_err, n_done, wr_obs.size(), cmd_obs.size());
            end
            hostq.delete();
        end
    endtask

    task automatic test_back_to_back();
        int both = 0;
        clr_obs();
        @(posedge p3_cmd_clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_len   = 7'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge p3_cmd_clk);
            if (req_ready && done) both++;
        end
        @(posedge p3_cmd_clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge p3_cmd_clk);
        n_cmp++;
        if (n_done != 5 || both != 0) begin
            n_fail++;
            $display("FAIL b2b: dones=%0d ready-with-done=%0d want 5 0", n_done, both);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clr_obs();
        for (int i = 0; i < 5; i++) hostq.push_back({4'hF, $urandom});
        @(posedge p3_cmd_clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 28'h2000;
        req_len   = 7'd16;
        @(posedge p3_cmd_clk);
        #1 req_valid = 1'b0;
        while (wr_obs.size() < 5 && k < 200) begin
            @(posedge p3_cmd_clk);
            #1 k++;
        end
        rst = 1'b1;
        @(posedge p3_cmd_clk);
        #1;
        @(negedge p3_cmd_clk);
        n_cmp++;
        if ({p3_wr_en, wdata_ready, p3_cmd_en, done, err, rdata_valid, p3_rd_en} !== 7'h0 ||
            req_ready !== calibration_done || wr_obs.size() != 5) begin
            n_fail++;
            $display("FAIL rst_mid: ctl=%b ready=%b beats=%0d want 0000000 1 5",
                     {p3_wr_en, wdata_ready, p3_cmd_en, done, err, rdata_valid, p3_rd_en},
                     req_ready, wr_obs.size());
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 11; i++) hostq.push_back({4'hF, $urandom});
        repeat (40) @(posedge p3_cmd_clk);
        n_cmp++;
        if (wr_obs.size() != 5 || cmd_obs.size() != 0 || n_done != 0) begin
            n_fail++;
            $display("FAIL rst_after: beats=%0d cmds=%0d dones=%0d want 5 0 0",
                     wr_obs.size(), cmd_obs.size(), n_done);
        end
        hostq.delete();
    endtask

    task automatic test_cal_gate();
        int seen = 0;
        clr_obs();
        for (int i = 0; i < 4; i++) hostq.push_back({4'hF, $urandom});
        @(posedge p3_cmd_clk);
        #1;
        calibration_done = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_len   = 7'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge p3_cmd_clk);
            if (req_ready) seen++;
        end
        @(posedge p3_cmd_clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge p3_cmd_clk);
        n_cmp++;
        if (seen != 0 || n_done != 0 || wr_obs.size() != 0) begin
            n_fail++;
            $display("FAIL cal_gate: ready=%0d dones=%0d beats=%0d want 0 0 0",
                     seen, n_done, wr_obs.size());
        end
        hostq.delete();
        #1 calibration_done = 1'b1;
    endtask

    task automatic test_cal_drop();
        int acc;
        bit tout;
        clr_obs();
        rd_src.delete();
        for (int i = 0; i < 8; i++) begin
            rd_src.push_back($urandom);
            rfifo.push_back(rd_src[i]);
        end
        fork
            do_req(1'b0, 28'h300, 7'd8, acc, tout);
            begin
                int k = 0;
                while (cmd_obs.size() == 0 && k < 100) begin
                    @(posedge p3_cmd_clk);
                    #1 k++;
                end
                calibration_done = 1'b0;
            end
        join
        n_cmp++;
        if (tout || done_err || rd_obs.size() != 8 || rd_obs != rd_src || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cal_drop: timeout=%0b err=%0b words=%0d ready=%b want 0 0 8 0",
                     tout, done_err, rd_obs.size(), req_ready);
        end
        #1 calibration_done = 1'b1;
    endtask

    task automatic test_random();
        int acc, l;
        bit tout, w;
        logic [27:0] a;
        logic [35:0] e;
        logic [38:0] exp_cmd;
        rnd_full = 1'b1;
        rnd_wgap = 1'b1;
        rnd_empty = 1'b1;
        for (int t = 0; t < 24; t++) begin
            w = 1'($urandom_range(1));
            l = $urandom_range(64, 1);
            a = 28'($urandom);
            exp_wr.delete();
            rd_src.delete();
            for (int i = 0; i < l; i++) begin
                e = {4'($urandom), $urandom};
                if (w) begin
                    hostq.push_back(e);
                    exp_wr.push_back({~e[35:32], e[31:0]});
                end else begin
                    rfifo.push_back(e[31:0]);
                    rd_src.push_back(e[31:0]);
                end
            end
            exp_cmd = {w ? 3'b010 : 3'b011, 6'(l - 1), a, 2'b00};
            clr_obs();
            do_req(w, a, 7'(l), acc, tout);
            n_cmp++;
            if (tout || n_done != 1 || done_err || cmd_obs.size() != 1 ||
                cmd_obs[0] !== exp_cmd || d0_instr_obs.size() != 1 ||
                d0_instr_obs[0] !== {2'b00, ~w}) begin
                n_fail++;
                $display("FAIL rnd%0d_cmd: w=%0b len=%0d got n=%0d %h want %h (tout=%0b err=%0b)",
                         t, w, l, cmd_obs.size(), (cmd_obs.size() > 0) ? cmd_obs[0] : 39'h0,
                         exp_cmd, tout, done_err);
            end
            n_cmp++;
            if (w ? (wr_obs != exp_wr || cmd_cyc <= last_wr_cyc || done_cyc != cmd_cyc)
                  : (rd_obs != rd_src || done_cyc != last_rdv_cyc)) begin
                n_fail++;
                $display("FAIL rnd%0d_data: w=%0b len=%0d beats=%0d words=%0d cmd@%0d done@%0d",
                         t, w, l, wr_obs.size(), rd_obs.size(), cmd_cyc, done_cyc);
            end
        end
        rnd_full = 1'b0;
        rnd_wgap = 1'b0;
        rnd_empty = 1'b0;
        n_cmp++;
        if (hs_bad != 0 || rdy_bad != 0 || rd_bad != 0 || errnd_bad != 0) begin
            n_fail++;
            $display("FAIL invariants: hs=%0d rdy=%0d rd=%0d err=%0d want all 0",
                     hs_bad, rdy_bad, rd_bad, errnd_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_stall();
        test_read_64();
        test_read_timeout();
        test_illegal_len();
        test_back_to_back();
        test_reset_mid();
        test_cal_gate();
        test_cal_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
